// File: rtl/spi_reg_writer.sv
// SPI mode-0 master that sends one 16-bit register-write frame {1, addr[6:0], data[7:0]}
// per accepted command, with all pin outputs driven straight from registers.
module spi_reg_writer #(
    parameter int HALF_PERIOD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_t;

    localparam logic [7:0] HALF_RELOAD = 8'(HALF_PERIOD - 1);

    state_t      state_q;
    logic [7:0]  half_cnt_q;
    logic [3:0]  bit_cnt_q;
    logic [14:0] shift_q;
    logic        sclk_q;
    logic        copi_q;
    logic        ncs_q;
    logic        busy_q;
    logic        done_q;
    logic        ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            half_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            sclk_q     <= 1'b0;
            copi_q     <= 1'b0;
            ncs_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        // Bit 15 (write flag) goes out now; shift_q holds bits 14..0.
                        shift_q    <= {cmd_addr, cmd_data};
                        copi_q     <= 1'b1;
                        ncs_q      <= 1'b0;
                        sclk_q     <= 1'b0;
                        half_cnt_q <= HALF_RELOAD;
                        bit_cnt_q  <= 4'd15;
                        busy_q     <= 1'b1;
                        ready_q    <= 1'b0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    if (half_cnt_q == 8'd0) begin
                        sclk_q     <= 1'b1;
                        half_cnt_q <= HALF_RELOAD;
                        state_q    <= SHIFT;
                    end else begin
                        half_cnt_q <= half_cnt_q - 8'd1;
                    end
                end
                SHIFT: begin
                    if (half_cnt_q == 8'd0) begin
                        half_cnt_q <= HALF_RELOAD;
                        if (sclk_q) begin
                            // Falling edge: present the next bit, except after bit 0.
                            sclk_q <= 1'b0;
                            if (bit_cnt_q != 4'd0) begin
                                copi_q  <= shift_q[14];
                                shift_q <= {shift_q[13:0], 1'b0};
                            end
                        end else if (bit_cnt_q == 4'd0) begin
                            ncs_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= GAP;
                        end else begin
                            sclk_q    <= 1'b1;
                            bit_cnt_q <= bit_cnt_q - 4'd1;
                        end
                    end else begin
                        half_cnt_q <= half_cnt_q - 8'd1;
                    end
                end
                GAP: begin
                    if (half_cnt_q == 8'd0) begin
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        half_cnt_q <= half_cnt_q - 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = ready_q;
    assign sclk      = sclk_q;
    assign copi      = copi_q;
    assign ncs       = ncs_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
